blake2b_nonce_sched: RTL and testbench

Work controller that drives the fully pipelined BLAKE2b hasher. It accepts a work unit (80-byte header, 256-bit target, start nonce, nonce count) and issues one header per cycle with the nonce inserted. It realigns each returning hash with its nonce through a LATENCY-deep tag pipe and pushes every hash strictly below target into a result FIFO. It sits between the host/work interface and the hasher instance.

---
 rtl/blake2b_pkg.sv | 31 +++
 rtl/blake2b_result_fifo.sv | 67 ++++++
 rtl/blake2b_nonce_sched.sv | 138 +++++++++++++
 tb/tb_blake2b_nonce_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2b_pkg.sv
// Shared widths, FSM states and result payload for the BLAKE2b nonce scheduler.
package blake2b_pkg;

  localparam int unsigned HEADER_W  = 640;
  localparam int unsigned HASH_W    = 256;
  localparam int unsigned NONCE_W   = 64;
  localparam int unsigned NONCE_LSB = 320;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [NONCE_W-1:0] nonce;
    logic [HASH_W-1:0]  hash;
  } result_t;

  // Header bytes are MSB-first, so the little-endian nonce puts its LSB byte in the top byte of the field.
  function automatic logic [HEADER_W-1:0] insert_nonce(input logic [HEADER_W-1:0] hdr,
                                                       input logic [NONCE_W-1:0]  nonce);
    logic [HEADER_W-1:0] h;
    h = hdr;
    for (int b = 0; b < int'(NONCE_W / 8); b++) begin
      h[NONCE_LSB + NONCE_W - 8 - 8 * b +: 8] = nonce[8 * b +: 8];
    end
    return h;
  endfunction

endpackage

// File: rtl/blake2b_result_fifo.sv
// First-word-fall-through result FIFO built as a shift register so the head is always a flop.
module blake2b_result_fifo
  import blake2b_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  result_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    valid,
  output result_t head
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  result_t           mem_q [DEPTH];
  result_t           mem_n [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_n;
  logic [CNT_W-1:0]  wr_idx;
  logic              pop_ok;
  logic              push_ok;

  // Pop shifts everything down one slot; a push lands just above the surviving entries.
  always_comb begin
    pop_ok  = pop && valid;
    push_ok = push && (!full || pop_ok);
    wr_idx  = pop_ok ? CNT_W'(count_q - CNT_W'(1)) : count_q;
    count_n = count_q;
    if (push_ok && !pop_ok) begin
      count_n = CNT_W'(count_q + CNT_W'(1));
    end else if (!push_ok && pop_ok) begin
      count_n = CNT_W'(count_q - CNT_W'(1));
    end
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      mem_n[i] = pop_ok ? mem_q[i + 1] : mem_q[i];
    end
    mem_n[DEPTH-1] = mem_q[DEPTH-1];
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (push_ok && (wr_idx == CNT_W'(i))) begin
        mem_n[i] = push_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      full    <= 1'b0;
      valid   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_n;
      full    <= (count_n == CNT_W'(DEPTH));
      valid   <= (count_n != '0);
      mem_q   <= mem_n;
    end
  end

  assign head = mem_q[0];

endmodule

// File: rtl/blake2b_nonce_sched.sv
// Issues one nonce-stamped header per cycle to the BLAKE2b pipeline and collects hashes below target.
module blake2b_nonce_sched
  import blake2b_pkg::*;
#(
  parameter int unsigned LATENCY    = 97,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                work_valid,
  output logic                work_ready,
  input  logic [HEADER_W-1:0] work_header,
  input  logic [HASH_W-1:0]   work_target,
  input  logic [NONCE_W-1:0]  work_nonce_start,
  input  logic [31:0]         work_nonce_count,
  input  logic                abort,
  output logic [HEADER_W-1:0] hdr_out,
  input  logic [HASH_W-1:0]   hash_in,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic [HASH_W-1:0]   res_hash,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  state_t               state;
  logic [HEADER_W-1:0]  hdr_q;
  logic [HASH_W-1:0]    target_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [31:0]          remaining_q;
  logic [LATENCY-1:0]   tag_v;
  logic [NONCE_W-1:0]   tag_n [LATENCY];
  logic                 any_valid;
  logic                 hit;
  logic                 drop;
  logic                 fifo_full;
  result_t              hit_data;
  result_t              fifo_head;

  assign any_valid = |tag_v;
  assign hit       = tag_v[LATENCY-1] && (hash_in < target_q) && !abort;
  assign drop      = hit && fifo_full && !(res_valid && res_ready);
  assign hit_data  = '{nonce: tag_n[LATENCY-1], hash: hash_in};

  // Tag nonces need no reset: only the valid bits decide whether a slot means anything.
  always_ff @(posedge clk) begin
    tag_n[0] <= nonce_q;
    for (int i = 1; i < int'(LATENCY); i++) begin
      tag_n[i] <= tag_n[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hdr_q       <= '0;
      target_q    <= '0;
      nonce_q     <= '0;
      remaining_q <= '0;
      tag_v       <= '0;
      hdr_out     <= '0;
      work_ready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done  <= 1'b0;
      tag_v <= {tag_v[LATENCY-2:0], 1'b0};
      if (abort) begin
        state      <= IDLE;
        tag_v      <= '0;
        work_ready <= 1'b1;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (work_valid && work_ready) begin
              hdr_q       <= work_header;
              target_q    <= work_target;
              nonce_q     <= work_nonce_start;
              remaining_q <= work_nonce_count;
              overflow    <= 1'b0;
              work_ready  <= 1'b0;
              busy        <= 1'b1;
              state       <= (work_nonce_count != '0) ? RUN : DRAIN;
            end else begin
              work_ready <= 1'b1;
            end
          end
          RUN: begin
            hdr_out     <= insert_nonce(hdr_q, nonce_q);
            tag_v       <= {tag_v[LATENCY-2:0], 1'b1};
            nonce_q     <= nonce_q + 64'd1;
            remaining_q <= remaining_q - 32'd1;
            if (remaining_q == 32'd1) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (!any_valid) begin
              state      <= IDLE;
              done       <= 1'b1;
              work_ready <= 1'b1;
              busy       <= 1'b0;
            end
          end
          default: begin
            state      <= IDLE;
            work_ready <= 1'b1;
            busy       <= 1'b0;
          end
        endcase
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  blake2b_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (hit),
    .push_data (hit_data),
    .pop       (res_ready),
    .full      (fifo_full),
    .valid     (res_valid),
    .head      (fifo_head)
  );

  assign res_nonce = fifo_head.nonce;
  assign res_hash  = fifo_head.hash;

endmodule

// File: tb/tb_blake2b_nonce_sched.sv
// Scoreboard bench for blake2b_nonce_sched driven by a fixed-latency behavioural hasher.
module tb_blake2b_nonce_sched;

  localparam int LAT   = 97;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0]  n;
    logic [255:0] h;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         work_valid = 1'b0;
  logic         work_ready;
  logic [639:0] work_header = '0;
  logic [255:0] work_target = '0;
  logic [63:0]  work_nonce_start = '0;
  logic [31:0]  work_nonce_count = '0;
  logic         abort = 1'b0;
  logic [639:0] hdr_out;
  logic [255:0] hash_in;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [63:0]  res_nonce;
  logic [255:0] res_hash;
  logic         busy;
  logic         done;
  logic         overflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  exp_t expq[$];
  logic [255:0] hpipe [LAT-1];
  logic [639:0] hdr_c;
  logic [255:0] ones = '1;

  blake2b_nonce_sched #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .work_valid(work_valid), .work_ready(work_ready),
    .work_header(work_header), .work_target(work_target),
    .work_nonce_start(work_nonce_start), .work_nonce_count(work_nonce_count),
    .abort(abort), .hdr_out(hdr_out), .hash_in(hash_in), .res_valid(res_valid),
    .res_ready(res_ready), .res_nonce(res_nonce), .res_hash(res_hash),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [639:0] ins(input logic [639:0] h, input logic [63:0] n);
    logic [639:0] r;
    logic [63:0]  sw;
    sw = {<<8{n}};
    r = h;
    r[383:320] = sw;
    return r;
  endfunction

  function automatic logic [255:0] model_hash(input logic [639:0] h);
    logic [63:0]  f;
    logic [63:0]  n;
    logic [191:0] p;
    f = h[383:320];
    n = {<<8{f}};
    p = 192'(n) * 192'(64'h9E37_79B9_7F4A_7C15);
    return {n, p ^ h[191:0]};
  endfunction

  // Behavioural hasher: hash of the header shown after edge k appears after edge k+LAT-1.
  always @(posedge clk) begin
    hpipe[0] <= model_hash(hdr_out);
    for (int j = 1; j < LAT - 1; j++) hpipe[j] <= hpipe[j-1];
  end
  assign hash_in = hpipe[LAT-2];

  // Result monitor: every pop must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected nonce=%h required none", res_nonce);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if (res_nonce !== e.n || res_hash !== e.h) begin
          errors++;
          $display("FAIL result nonce=%h hash=%h required nonce=%h hash=%h",
                   res_nonce, res_hash, e.n, e.h);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_w(input string name, input logic [639:0] act, input logic [639:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [639:0] h, input logic [255:0] tg, input logic [63:0] st,
                       input logic [31:0] n, input int keep, output int t);
    int k;
    int kept;
    kept = 0;
    for (int i = 0; i < int'(n); i++) begin
      logic [63:0]  nn;
      logic [255:0] hh;
      nn = st + 64'(i);
      hh = model_hash(ins(h, nn));
      if (hh < tg && kept < keep) begin
        expq.push_back('{n: nn, h: hh});
        kept++;
      end
    end
    k = 0;
    while (work_ready !== 1'b1 && k < 500) begin
      tick(1);
      k++;
    end
    chk("ready_before_issue", 64'(work_ready), 64'd1);
    work_valid = 1'b1;
    work_header = h;
    work_target = tg;
    work_nonce_start = st;
    work_nonce_count = n;
    tick(1);
    t = cyc;
    work_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cyc, input int bound);
    int got;
    got = 0;
    for (int i = 0; i < bound; i++) begin
      tick(1);
      if (done === 1'b1) begin
        got = cyc;
        break;
      end
    end
    chk(name, 64'(got), 64'(exp_cyc));
  endtask

  initial begin
    int t;
    int d0;
    logic [255:0] tgt;
    for (int i = 0; i < 10; i++) hdr_c[64*i +: 64] = 64'hA5A5_0000_1111_2222 + 64'(i) * 64'h0101_0101_0101_0101;
    hdr_c[383:320] = '1;

    // Reset state
    #2;
    chk("rst_work_ready", 64'(work_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk_w("rst_hdr_out", hdr_out, '0);
    chk("rst_res_hash", res_hash[63:0], 64'd0);
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("ready_after_reset", 64'(work_ready), 64'd1);

    // All-ones target, three nonces
    issue(hdr_c, ones, 64'h10, 32'd3, 100, t);
    tick(1);
    chk_w("first_hdr_out", hdr_out, ins(hdr_c, 64'h10));
    chk("busy_run", 64'(busy), 64'd1);
    chk("ready_run", 64'(work_ready), 64'd0);
    wait_done("done_n3", t + 3 + LAT + 1, 300);
    chk("ready_at_done", 64'(work_ready), 64'd1);
    tick(5);

    // Zero target: nothing can hit
    d0 = done_cnt;
    issue(hdr_c, '0, 64'h500, 32'd100, 100, t);
    wait_done("done_n100", t + 100 + LAT + 1, 400);
    tick(5);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("no_overflow_t0", 64'(overflow), 64'd0);

    // Nonce wrap
    issue(hdr_c, ones, 64'hFFFF_FFFF_FFFF_FFFE, 32'd4, 100, t);
    wait_done("done_wrap", t + 4 + LAT + 1, 300);
    tick(5);

    // Zero count finishes the cycle after accept
    issue(hdr_c, ones, 64'h77, 32'd0, 100, t);
    wait_done("done_n0", t + 1, 10);
    tick(2);

    // FIFO overflow with consumer stalled
    res_ready = 1'b0;
    issue(hdr_c, ones, 64'h40, 32'd8, DEPTH, t);
    wait_done("done_ovf", t + 8 + LAT + 1, 300);
    chk("overflow_set", 64'(overflow), 64'd1);
    chk("res_valid_full", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    tick(6);
    chk("drain_queue", 64'(expq.size()), 64'd0);
    chk("res_valid_drained", 64'(res_valid), 64'd0);

    // Strict compare: hash equal to target is not a hit
    tgt = model_hash(ins(hdr_c, 64'h14));
    issue(hdr_c, tgt, 64'h10, 32'd8, 100, t);
    chk("overflow_cleared", 64'(overflow), 64'd0);
    wait_done("done_strict", t + 8 + LAT + 1, 300);
    tick(5);

    // Abort mid-run; abort also beats a concurrent work_valid
    d0 = done_cnt;
    issue(hdr_c, ones, 64'h1000, 32'd1000, 0, t);
    tick(4);
    abort = 1'b1;
    work_valid = 1'b1;
    tick(1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(work_ready), 64'd1);
    tick(1);
    chk("abort_wins_accept", 64'(busy), 64'd0);
    abort = 1'b0;
    work_valid = 1'b0;
    tick(LAT + 20);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    issue(hdr_c, ones, 64'h2000, 32'd2, 100, t);
    wait_done("done_after_abort", t + 2 + LAT + 1, 300);
    tick(5);

    // Reset while draining
    d0 = done_cnt;
    issue(hdr_c, ones, 64'h3000, 32'd3, 0, t);
    tick(6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(work_ready), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk_w("mid_rst_hdr_out", hdr_out, '0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("ready_after_mid_rst", 64'(work_ready), 64'd1);
    tick(LAT + 20);
    chk("no_stale_done", 64'(done_cnt - d0), 64'd0);
    chk("final_queue_empty", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
